// File: rtl/cla_pipelined_adder.sv
// Pipelined carry look-ahead adder: one BLOCK-bit look-ahead slice per stage, block carry registered between stages.
// Build option CLA_ADDSUB_EN adds the sub port (a + ~b + 1).
`timescale 1ns/1ps
module cla_pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    localparam int NBLK = WIDTH / BLOCK;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("cla_pipelined_adder: WIDTH must be a positive multiple of BLOCK");
    end

    // Returns {carry_out, sum}; every carry is a flat sum of products of g/p and ci.
    function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             ci);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i+1] = term | (pp & ci);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_cap;
    logic             ci_cap;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef CLA_ADDSUB_EN
    assign b_cap  = sub ? ~b : b;
    assign ci_cap = sub | c_in;
`else
    assign b_cap  = b;
    assign ci_cap = c_in;
`endif

    // x holds finished sum bits below LO and untouched A bits from LO up; rb holds only unused B bits.
    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int LO  = k * BLOCK;
        localparam int REM = WIDTH - LO;

        logic             v;
        logic             cy;
        logic [WIDTH-1:0] x;
        logic [REM-1:0]   rb;
        logic [BLOCK:0]   res;
        logic [WIDTH-1:0] x_nxt;

        always_comb begin
            res               = cla_slice(x[LO +: BLOCK], rb[BLOCK-1:0], cy);
            x_nxt             = x;
            x_nxt[LO +: BLOCK] = res[BLOCK-1:0];
        end

        if (k == 0) begin : g_ld
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v  <= 1'b0;
                    cy <= 1'b0;
                    x  <= '0;
                    rb <= '0;
                end else if (adv) begin
                    v <= in_valid;
                    if (in_valid) begin
                        x  <= a;
                        rb <= b_cap;
                        cy <= ci_cap;
                    end
                end
            end
        end else begin : g_ld
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v  <= 1'b0;
                    cy <= 1'b0;
                    x  <= '0;
                    rb <= '0;
                end else if (adv) begin
                    v <= g_stg[k-1].v;
                    if (g_stg[k-1].v) begin
                        x  <= g_stg[k-1].x_nxt;
                        rb <= g_stg[k-1].rb[REM+BLOCK-1:BLOCK];
                        cy <= g_stg[k-1].res[BLOCK];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
        end else if (adv) begin
            out_valid <= g_stg[NBLK-1].v;
            if (g_stg[NBLK-1].v) begin
                s     <= g_stg[NBLK-1].x_nxt;
                c_out <= g_stg[NBLK-1].res[BLOCK];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Scoreboard bench for cla_pipelined_adder: 16/4 instance driven randomly and directed, plus an 8/4 instance.
// Build with CLA_ADDSUB_EN defined to also exercise subtraction.
`timescale 1ns/1ps
module tb_cla_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
`ifdef CLA_ADDSUB_EN
    logic        sub = 1'b0;
    logic        sub8 = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] s;
    logic        c_out;

    logic        in8_valid = 1'b0;
    logic        in8_ready;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        c8_in = 1'b0;
    logic        out8_valid;
    logic        out8_ready = 1'b1;
    logic [7:0]  s8;
    logic        c8_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_out = 0;
    logic [16:0] sb_q[$];
    bit          done = 1'b0;

    cla_pipelined_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
`ifdef CLA_ADDSUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out)
    );

    cla_pipelined_adder #(.WIDTH(8), .BLOCK(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready),
        .a(a8), .b(b8), .c_in(c8_in),
`ifdef CLA_ADDSUB_EN
        .sub(sub8),
`endif
        .out_valid(out8_valid), .out_ready(out8_ready), .s(s8), .c_out(c8_out)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic sb);
        if (sb) return {1'b0, x} + {1'b0, ~y} + 17'd1;
        return {1'b0, x} + {1'b0, y} + {16'd0, ci};
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected completion at %0t", name, $time);
    endtask

    // Monitor: whatever the DUT presents must equal the oldest outstanding model result.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %0h expected no output at %0t",
                         {c_out, s}, $time);
            end else begin
                chk("sum", 32'({c_out, s}), 32'(sb_q[0]));
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tci, input logic tsub);
        bit got = 1'b0;
        a = ta; b = tb_v; c_in = tci; in_valid = 1'b1;
`ifdef CLA_ADDSUB_EN
        sub = tsub;
`endif
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                sb_q.push_back(ref_sum(ta, tb_v, tci, tsub));
            end
            @(posedge clk); #1;
        end
        if (!got) fail_now("send_timeout");
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int w = 0; w < 100 && sb_q.size() != 0; w++) @(posedge clk);
        if (sb_q.size() != 0) fail_now("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] t2_exp [3] = '{17'h05555, 17'h10000, 17'h01000};
        logic [15:0] pa, pb;
        logic        pc;
        int          n0;
        logic        rsub;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'({c_out, s}), 32'd0);
        chk("rst_out8_valid", 32'(out8_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 1: carry crosses all stages, latency 4
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            chk("t1_latency", 32'(out_valid), 32'(i == 4));
        end
        chk("t1_result", 32'({c_out, s}), 32'h10000);
        drain();

        // 2: back-to-back, consecutive results
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        send(16'h0FFF, 16'h0000, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_valid", 32'(out_valid), 32'(i >= 2));
            if (i >= 2) chk("t2_sum", 32'({c_out, s}), 32'(t2_exp[i-2]));
        end
        drain();

        // 3: full pipeline, 3-cycle stall
        n0 = n_out;
        for (int i = 0; i < 5; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'b0);
        out_ready = 1'b0;
        pa = rnd_op(); pb = rnd_op(); pc = 1'($urandom);
        a = pa; b = pb; c_in = pc; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_in_ready_stall", 32'(in_ready), 32'd0);
            chk("t3_out_valid_stall", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(pa, pb, pc, 1'b0);
        idle();
        drain();
        chk("t3_count", 32'(n_out - n0), 32'd6);

        // random traffic with random back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    rsub = 1'b0;
`ifdef CLA_ADDSUB_EN
                    rsub = 1'($urandom);
`endif
                    send(rnd_op(), rnd_op(), 1'($urandom), rsub);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 4: reset with results in flight
        n0 = n_out;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(rnd_op(), rnd_op(), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("t4_out_valid_async", 32'(out_valid), 32'd0);
        chk("t4_sum_async", 32'({c_out, s}), 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'hABCD, 16'h1234, 1'b1, 1'b0);
        idle();
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("t4_single_emit", 32'(n_out - n0), 32'd1);

`ifdef CLA_ADDSUB_EN
        // 5: subtraction
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1);
        idle();
        sub = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("t5_sub_neg", 32'({c_out, s}), 32'h0FFFE);
        @(negedge clk);
        chk("t5_sub_pos", 32'({c_out, s}), 32'h10002);
        drain();
`endif

        // 6: WIDTH=8 BLOCK=4, latency 2
        a8 = 8'hFF; b8 = 8'hFF; c8_in = 1'b1; in8_valid = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 32'(in8_ready), 32'd1);
        @(posedge clk); #1;
        in8_valid = 1'b0;
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            chk("t6_latency", 32'(out8_valid), 32'(i == 2));
        end
        chk("t6_sum", 32'({c8_out, s8}), 32'h1FF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
